// File: rtl/snoop_pkg.sv
// Shared types for the D-cache snoop responder.
// ACE AC/CR/CD channel bundles, snoop encodings and FSM states.
package snoop_pkg;

  localparam int unsigned DCACHE_SET_ASSOC   = 4;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 20;
  localparam int unsigned AC_ADDR_W          = 64;
  localparam int unsigned CD_DATA_W          = 64;

  typedef enum logic [3:0] {
    SNP_READ_ONCE     = 4'b0000,
    SNP_READ_SHARED   = 4'b0001,
    SNP_READ_CLEAN    = 4'b0010,
    SNP_READ_NSD      = 4'b0011,
    SNP_READ_UNIQUE   = 4'b0111,
    SNP_CLEAN_SHARED  = 4'b1000,
    SNP_CLEAN_INVALID = 4'b1001,
    SNP_MAKE_INVALID  = 4'b1101
  } acsnoop_t;

  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  typedef struct packed {
    logic dt;
    logic pd;
    logic is;
    logic wr;
    logic inval;
    logic new_dirty;
    logic new_shared;
  } snoop_action_t;

  typedef struct packed {
    logic [AC_ADDR_W-1:0] addr;
    logic [3:0]           snoop;
  } ac_chan_t;

  typedef struct packed {
    logic [CD_DATA_W-1:0] data;
    logic                 last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic     ac_ready;
    logic     cr_valid;
    crresp_t  cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  } snoop_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    TAG_REQ,
    EVAL,
    WRITE_FLAGS,
    CR_RESP,
    CD_DATA
  } state_t;

endpackage

// File: rtl/snoop_decode.sv
// Snoop type + lookup result to response/flag-update action.
// Purely combinational; a miss always yields an all-zero action.
module snoop_decode
  import snoop_pkg::*;
(
  input  logic          i_pass_dirty_en,
  input  logic [3:0]    i_snoop,
  input  logic          i_hit,
  input  logic          i_dirty,
  input  logic          i_shared,
  output snoop_action_t o_act,
  output logic          o_supported
);

  // map snoop type and hit-way flags to the action
  always_comb begin
    o_act       = '0;
    o_supported = 1'b0;
    unique case (i_snoop)
      SNP_READ_ONCE: begin
        o_supported = 1'b1;
        o_act.dt    = 1'b1;
        o_act.is    = i_shared;
      end
      SNP_READ_SHARED,
      SNP_READ_CLEAN,
      SNP_READ_NSD: begin
        o_supported      = 1'b1;
        o_act.dt         = 1'b1;
        o_act.is         = 1'b1;
        o_act.pd         = i_dirty & i_pass_dirty_en;
        o_act.wr         = 1'b1;
        o_act.new_shared = 1'b1;
        o_act.new_dirty  = i_dirty & ~i_pass_dirty_en;
      end
      SNP_READ_UNIQUE: begin
        o_supported = 1'b1;
        o_act.dt    = 1'b1;
        o_act.pd    = i_dirty;
        o_act.wr    = 1'b1;
        o_act.inval = 1'b1;
      end
      SNP_CLEAN_INVALID: begin
        o_supported = 1'b1;
        o_act.dt    = i_dirty;
        o_act.pd    = i_dirty;
        o_act.wr    = 1'b1;
        o_act.inval = 1'b1;
      end
      SNP_CLEAN_SHARED: begin
        o_supported      = 1'b1;
        o_act.dt         = i_dirty;
        o_act.pd         = i_dirty;
        o_act.is         = 1'b1;
        o_act.wr         = i_dirty;
        o_act.new_shared = i_shared;
      end
      SNP_MAKE_INVALID: begin
        o_supported = 1'b1;
        o_act.wr    = 1'b1;
        o_act.inval = 1'b1;
      end
      default: begin
        o_supported = 1'b0;
      end
    endcase
    if (!i_hit) o_act = '0;
  end

endmodule

// File: rtl/snoop_resp_unit.sv
// ACE snoop responder for the write-back D-cache.
// AC accept, tag lookup, flag update, CR answer and CD burst.
module snoop_resp_unit
  import snoop_pkg::*;
#(
  parameter int unsigned NumWays     = DCACHE_SET_ASSOC,
  parameter int unsigned IndexWidth  = DCACHE_INDEX_WIDTH,
  parameter int unsigned TagWidth    = DCACHE_TAG_WIDTH,
  parameter int unsigned LineWidth   = 128,
  parameter int unsigned BeatWidth   = 64,
  parameter bit          PassDirtyEn = 1'b1,
  localparam int unsigned ClWidth    = TagWidth + LineWidth + 3,
  localparam int unsigned TagBeW     = (TagWidth + 7) / 8,
  localparam int unsigned BeWidth    = TagBeW + LineWidth / 8 + NumWays
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           bypass_i,
  input  logic                           flushing_i,
  input  logic                           updating_cache_i,
  output logic                           busy_o,
  input  snoop_req_t                     snoop_port_i,
  output snoop_resp_t                    snoop_port_o,
  output logic [NumWays-1:0]             req_o,
  output logic [IndexWidth-1:0]          addr_o,
  output logic [TagWidth-1:0]            tag_o,
  output logic                           we_o,
  output logic [BeWidth-1:0]             be_o,
  output logic [ClWidth-1:0]             data_o,
  input  logic                           gnt_i,
  input  logic [ClWidth-1:0]             data_i [NumWays],
  input  logic [NumWays-1:0]             hit_way_i,
  input  logic [NumWays-1:0]             dirty_way_i,
  input  logic [NumWays-1:0]             shared_way_i,
  output logic                           inval_o,
  output logic [TagWidth+IndexWidth-1:0] inval_addr_o
);

  localparam int unsigned Beats = LineWidth / BeatWidth;
  localparam int unsigned BCW   = (Beats > 1) ? $clog2(Beats) : 1;

  typedef struct packed {
    logic [TagWidth-1:0]  tag;
    logic [LineWidth-1:0] data;
    logic                 valid;
    logic                 dirty;
    logic                 shared;
  } cache_line_t;

  typedef struct packed {
    logic [TagBeW-1:0]      tag;
    logic [LineWidth/8-1:0] data;
    logic [NumWays-1:0]     vldrty;
  } cl_be_t;

  state_t               r_state;
  logic [IndexWidth-1:0] r_index;
  logic [TagWidth-1:0]  r_tag;
  logic [3:0]           r_snoop;
  crresp_t              r_cr;
  snoop_action_t        r_act;
  logic [NumWays-1:0]   r_hit_way;
  logic [LineWidth-1:0] r_line;
  logic [BCW-1:0]       r_beat;

  logic [ClWidth-1:0]   w_line_sel;
  cache_line_t          w_line;
  logic [3:0]           w_dec_snoop;
  logic                 w_hit;
  logic                 w_d;
  logic                 w_s;
  snoop_action_t        w_act;
  logic                 w_sup;
  logic                 w_last;
  logic [BeatWidth-1:0] w_beat;
  cl_be_t               w_be;
  cache_line_t          w_wr;
  logic                 w_unused;

  assign w_hit = |hit_way_i;
  assign w_d   = |(hit_way_i & dirty_way_i);
  assign w_s   = |(hit_way_i & shared_way_i);

  // in IDLE the incoming snoop is screened, later the captured one
  assign w_dec_snoop = (r_state == IDLE) ? snoop_port_i.ac.snoop
                                         : r_snoop;

  snoop_decode u_decode (
    .i_pass_dirty_en (PassDirtyEn),
    .i_snoop         (w_dec_snoop),
    .i_hit           (w_hit),
    .i_dirty         (w_d),
    .i_shared        (w_s),
    .o_act           (w_act),
    .o_supported     (w_sup)
  );

  // select the hitting way's line (one-hot hit vector)
  always_comb begin
    w_line_sel = '0;
    for (int w = 0; w < NumWays; w++) begin
      if (hit_way_i[w]) w_line_sel = w_line_sel | data_i[w];
    end
  end

  assign w_line = w_line_sel;

  assign w_last = (r_beat == BCW'(Beats - 1));
  assign w_beat = r_line[32'(r_beat) * BeatWidth +: BeatWidth];

  // snoop FSM: capture, lookup, flag write, CR, CD burst
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_index   <= '0;
      r_tag     <= '0;
      r_snoop   <= '0;
      r_cr      <= '0;
      r_act     <= '0;
      r_hit_way <= '0;
      r_line    <= '0;
      r_beat    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (snoop_port_i.ac_valid && !flushing_i) begin
            r_index <= snoop_port_i.ac.addr[IndexWidth-1:0];
            r_tag   <= snoop_port_i.ac.addr[TagWidth+IndexWidth-1:IndexWidth];
            r_snoop <= snoop_port_i.ac.snoop;
            r_cr    <= '0;
            r_act   <= '0;
            if (bypass_i) begin
              r_state <= CR_RESP;
            end else if (!w_sup) begin
              r_cr.error <= 1'b1;
              r_state    <= CR_RESP;
            end else begin
              r_state <= TAG_REQ;
            end
          end
        end
        TAG_REQ: begin
          if (gnt_i && !updating_cache_i) r_state <= EVAL;
        end
        EVAL: begin
          if (updating_cache_i) begin
            r_state <= TAG_REQ;
          end else begin
            r_hit_way            <= hit_way_i;
            r_line               <= w_line.data;
            r_act                <= w_act;
            r_cr.data_transfer   <= w_act.dt;
            r_cr.pass_dirty      <= w_act.pd;
            r_cr.is_shared       <= w_act.is;
            r_state <= w_act.wr ? WRITE_FLAGS : CR_RESP;
          end
        end
        WRITE_FLAGS: begin
          if (gnt_i) r_state <= CR_RESP;
        end
        CR_RESP: begin
          if (snoop_port_i.cr_ready) begin
            if (r_cr.data_transfer) begin
              r_beat  <= '0;
              r_state <= CD_DATA;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        CD_DATA: begin
          if (snoop_port_i.cd_ready) begin
            if (w_last) begin
              r_beat  <= '0;
              r_state <= IDLE;
            end else begin
              r_beat <= r_beat + BCW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // SRAM port and flag-write payload, decoded from state
  always_comb begin
    w_be      = '0;
    w_wr      = '0;
    req_o     = '0;
    we_o      = 1'b0;
    inval_o   = 1'b0;
    if (r_state == TAG_REQ && !updating_cache_i) begin
      req_o = '1;
    end
    if (r_state == WRITE_FLAGS) begin
      req_o       = r_hit_way;
      we_o        = 1'b1;
      w_be.vldrty = r_hit_way;
      w_wr.valid  = ~r_act.inval;
      w_wr.dirty  = r_act.new_dirty;
      w_wr.shared = r_act.new_shared;
      inval_o     = r_act.inval & gnt_i;
    end
  end

  assign be_o         = w_be;
  assign data_o       = w_wr;
  assign addr_o       = r_index;
  assign tag_o        = r_tag;
  assign inval_addr_o = {r_tag, r_index};
  assign busy_o       = (r_state != IDLE);

  // AC/CR/CD channel outputs
  always_comb begin
    snoop_port_o          = '0;
    snoop_port_o.ac_ready = (r_state == IDLE) && !flushing_i;
    snoop_port_o.cr_valid = (r_state == CR_RESP);
    snoop_port_o.cr_resp  = r_cr;
    if (r_state == CD_DATA) begin
      snoop_port_o.cd_valid = 1'b1;
      snoop_port_o.cd.data  = CD_DATA_W'(w_beat);
      snoop_port_o.cd.last  = w_last;
    end
  end

  assign w_unused = ^{w_line.tag, w_line.valid, w_line.dirty,
                      w_line.shared, r_act.dt, r_act.pd, r_act.is,
                      r_act.wr,
                      snoop_port_i.ac.addr[AC_ADDR_W-1:TagWidth+IndexWidth]};

endmodule
